// File: rtl/qam_rx_demap.sv
// qam_rx_demap: picks one oversampled I/Q sample per symbol, slices it to the
// nearest QPSK/QAM16/QAM64 point, Gray-decodes it to bits and queues the
// result in a small output FIFO with a valid/ready handshake.
module qam_rx_demap #(
    parameter int IW         = 8,
    parameter int OSR        = 4,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] i_in,
    input  logic signed [IW-1:0] q_in,
    input  logic                 sync,
    input  logic [CNT_W-1:0]     phase_sel,
    input  logic [1:0]           mode,
    output logic [CNT_W-1:0]     counter_v,
    output logic signed [3:0]    i_dec,
    output logic signed [3:0]    q_dec,
    output logic [DW-1:0]        og_data,
    output logic                 og_valid,
    input  logic                 out_ready,
    output logic [15:0]          sym_count,
    output logic [7:0]           overflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] OSR_W = (CNT_W + 1)'(OSR);

    // Clamp x|1 into [-lim, lim]. lim is odd, so clamping on x itself gives
    // the same result as clamping x|1, and in range only the low bits matter.
    function automatic logic [3:0] slice_level(input logic signed [IW-1:0] x,
                                               input logic [2:0] lim);
        logic signed [IW-1:0] lim_s;
        lim_s = $signed({{(IW-3){1'b0}}, lim});
        if (x > lim_s)
            return {1'b0, lim};
        else if (x < -lim_s)
            return ~{1'b0, lim} + 4'd1;
        else
            return {x[3:1], 1'b1};
    endfunction

    // Map a level in [-lim, lim] to its index n = (level+lim)/2, then Gray code.
    function automatic logic [2:0] level_gray(input logic [3:0] level,
                                              input logic [2:0] lim);
        logic [2:0] n;
        n = 3'((level + {1'b0, lim}) >> 1);
        return n ^ (n >> 1);
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_phase;
    logic [CNT_W:0]   next_phase;
    logic             take;

    logic                 s1_valid;
    logic signed [IW-1:0] s1_i;
    logic signed [IW-1:0] s1_q;
    logic [1:0]           s1_mode;

    logic [2:0]    lim;
    logic [3:0]    lvl_i;
    logic [3:0]    lvl_q;
    logic [2:0]    gray_i;
    logic [2:0]    gray_q;
    logic [DW-1:0] sym_w;

    logic          s2_valid;
    logic [DW-1:0] s2_data;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign counter_v = cnt;

    // Phase of the current sample (sync forces 0) and the phase after it.
    always_comb begin
        cur_phase  = sync ? '0 : cnt;
        next_phase = {1'b0, cur_phase} + (CNT_W + 1)'(1);
        if (next_phase >= OSR_W)
            next_phase = '0;
        take = in_valid && (cur_phase == phase_sel) && ({1'b0, phase_sel} < OSR_W);
    end

    // Phase counter advances on every valid sample.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (in_valid)
            cnt <= next_phase[CNT_W-1:0];
    end

    // Stage 1 captures the chosen sample together with its own mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_mode  <= 2'b00;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_i    <= i_in;
                s1_q    <= q_in;
                s1_mode <= mode;
            end
        end
    end

    // Slicer and Gray mapper; mode 11 behaves as QAM16.
    always_comb begin
        case (s1_mode)
            2'b00:   lim = 3'd1;
            2'b10:   lim = 3'd7;
            default: lim = 3'd3;
        endcase
        lvl_i  = slice_level(s1_i, lim);
        lvl_q  = slice_level(s1_q, lim);
        gray_i = level_gray(lvl_i, lim);
        gray_q = level_gray(lvl_q, lim);
        sym_w  = '0;
        case (s1_mode)
            2'b00:   sym_w[5:0] = {4'b0000, gray_i[0], gray_q[0]};
            2'b10:   sym_w[5:0] = {gray_i, gray_q};
            default: sym_w[5:0] = {2'b00, gray_i[1:0], gray_q[1:0]};
        endcase
    end

    // Stage 2 registers the decoded symbol and the sliced levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            i_dec    <= '0;
            q_dec    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sym_w;
                i_dec   <= lvl_i;
                q_dec   <= lvl_q;
            end
        end
    end

    // A write into a full FIFO only succeeds when the head leaves on the same edge.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = !empty && out_ready;
        push_ok = s2_valid && (!full || pop);
        drop    = s2_valid && full && !pop;
    end

    assign og_valid = !empty;
    assign og_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // FIFO storage needs no reset; the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= s2_data;
    end

    // FIFO pointers plus the written and dropped symbol counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sym_count    <= '0;
            overflow_cnt <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) begin
                wr_ptr    <= wr_ptr + 1'b1;
                sym_count <= sym_count + 16'd1;
            end
            if (drop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_qam_rx_demap.sv
// tb_qam_rx_demap: directed bench for qam_rx_demap with a reference slicer,
// a phase-counter model and a scoreboard FIFO model.
module tb_qam_rx_demap;

    localparam int IW         = 8;
    localparam int OSR        = 4;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int DW         = 6;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic signed [IW-1:0] i_in;
    logic signed [IW-1:0] q_in;
    logic                 sync;
    logic [CNT_W-1:0]     phase_sel;
    logic [1:0]           mode;
    logic [CNT_W-1:0]     counter_v;
    logic [3:0]           i_dec;
    logic [3:0]           q_dec;
    logic [DW-1:0]        og_data;
    logic                 og_valid;
    logic                 out_ready;
    logic [15:0]          sym_count;
    logic [7:0]           overflow_cnt;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } pend_t;

    pend_t         pend_q[$];
    logic [DW-1:0] fifo_q[$];
    int            m_phase;
    logic [15:0]   m_sym;
    int            m_ovf;
    int            edge_n;
    bit            checking;
    int            pass_count;
    int            fail_count;
    int            check_count;

    qam_rx_demap #(
        .IW(IW), .OSR(OSR), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .DW(DW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
        .sync(sync), .phase_sel(phase_sel), .mode(mode), .counter_v(counter_v),
        .i_dec(i_dec), .q_dec(q_dec), .og_data(og_data), .og_valid(og_valid),
        .out_ready(out_ready), .sym_count(sym_count), .overflow_cnt(overflow_cnt)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nearest odd level: 2*floor(x/2)+1, clamped to +/-lim.
    function automatic int ref_level(input int x, input int lim);
        int h;
        int lv;
        h  = (x >= 0) ? x / 2 : -((1 - x) / 2);
        lv = 2 * h + 1;
        if (lv > lim)  lv = lim;
        if (lv < -lim) lv = -lim;
        return lv;
    endfunction

    function automatic int ref_sym(input int x, input int y, input logic [1:0] m);
        int levels;
        int bits;
        int ni;
        int nq;
        case (m)
            2'b00:   begin levels = 2; bits = 1; end
            2'b10:   begin levels = 8; bits = 3; end
            default: begin levels = 4; bits = 2; end
        endcase
        ni = (ref_level(x, levels - 1) + levels - 1) / 2;
        nq = (ref_level(y, levels - 1) + levels - 1) / 2;
        return ((ni ^ (ni >> 1)) << bits) | (nq ^ (nq >> 1));
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: compare against the model, advance the model, then clock.
    task automatic step_clock();
        int    ph;
        pend_t p;
        if (checking) begin
            check_output("og_valid", og_valid, fifo_q.size() != 0);
            if (fifo_q.size() == 0)
                check_output("og_data_empty", og_data, 0);
            else if (out_ready)
                check_output("og_data_head", og_data, fifo_q[0]);
            check_output("counter_v", counter_v, m_phase);
        end
        if (reset) begin
            pend_q.delete();
            fifo_q.delete();
            m_phase = 0;
            m_sym   = '0;
            m_ovf   = 0;
        end else begin
            if (fifo_q.size() != 0 && out_ready)
                void'(fifo_q.pop_front());
            if (pend_q.size() != 0 && pend_q[0].due == edge_n) begin
                p = pend_q.pop_front();
                if (fifo_q.size() < FIFO_DEPTH) begin
                    fifo_q.push_back(p.data);
                    m_sym++;
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
            end
            if (in_valid) begin
                ph = sync ? 0 : m_phase;
                if (ph == int'(phase_sel) && int'(phase_sel) < OSR) begin
                    p.data = DW'(ref_sym(int'(i_in), int'(q_in), mode));
                    p.due  = edge_n + 2;
                    pend_q.push_back(p);
                end
                m_phase = (ph + 1) % OSR;
            end
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic apply_stimulus(input bit v, input bit s, input int i, input int q,
                                  input logic [1:0] m);
        in_valid = v;
        sync     = s;
        i_in     = 8'(i);
        q_in     = 8'(q);
        mode     = m;
        step_clock();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        sync     = 1'b0;
        repeat (n) step_clock();
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        sync     = 1'b0;
        reset    = 1'b1;
        step_clock();
        reset    = 1'b0;
    endtask

    // Directed sequence of test steps.
    initial begin
        int base;
        pass_count  = 0;
        fail_count  = 0;
        check_count = 0;
        checking    = 0;
        edge_n      = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        sync        = 1'b0;
        i_in        = '0;
        q_in        = '0;
        mode        = 2'b01;
        phase_sel   = '0;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pend_q.delete();
        fifo_q.delete();
        m_phase  = 0;
        m_sym    = '0;
        m_ovf    = 0;
        reset    = 1'b0;
        checking = 1;

        $display("[TB] reset state");
        check_output("rst_counter_v", counter_v, 0);
        check_output("rst_i_dec", i_dec, 0);
        check_output("rst_q_dec", q_dec, 0);
        check_output("rst_og_valid", og_valid, 0);
        check_output("rst_og_data", og_data, 0);
        check_output("rst_sym_count", sym_count, 0);
        check_output("rst_overflow_cnt", overflow_cnt, 0);

        $display("[TB] basic QAM16 symbol");
        apply_stimulus(1, 1, 3, -1, 2'b01);
        idle(1);
        check_output("t1_i_dec", i_dec, 4'd3);
        check_output("t1_q_dec", q_dec, 4'hF);
        idle(1);
        check_output("t1_og_valid", og_valid, 1);
        check_output("t1_og_data", og_data, 6'h09);
        check_output("t1_sym_count", sym_count, 1);
        idle(1);
        check_output("t1_og_valid_fall", og_valid, 0);

        $display("[TB] clamp, tie and mode switching");
        apply_stimulus(1, 1, 100, -128, 2'b01);
        apply_stimulus(1, 1, 0, 2, 2'b01);
        check_output("t2_i_dec_clamp", i_dec, 4'd3);
        check_output("t2_q_dec_clamp", q_dec, 4'hD);
        apply_stimulus(1, 1, 5, -7, 2'b10);
        check_output("t2_i_dec_tie", i_dec, 4'd1);
        check_output("t2_q_dec_tie", q_dec, 4'd3);
        apply_stimulus(1, 1, -1, 1, 2'b00);
        check_output("t2_i_dec_qam64", i_dec, 4'd5);
        check_output("t2_q_dec_qam64", q_dec, 4'h9);
        apply_stimulus(1, 1, 3, -1, 2'b11);
        apply_stimulus(1, 1, -20, 9, 2'b10);
        idle(4);
        check_output("t2_sym_count", sym_count, 7);

        $display("[TB] overflow and drain");
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            apply_stimulus(1, 1, k * 2 - 5, 4 - k * 3, 2'b10);
        idle(3);
        check_output("t3_og_valid", og_valid, 1);
        check_output("t3_sym_count", sym_count, 4);
        check_output("t3_overflow_cnt", overflow_cnt, 2);
        out_ready = 1'b1;
        idle(6);
        check_output("t3_drained", og_valid, 0);

        $display("[TB] write into full FIFO with simultaneous pop");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            apply_stimulus(1, 1, 7 - k * 3, k - 2, 2'b01);
        idle(1);
        out_ready = 1'b1;
        idle(8);
        check_output("t4_sym_count", sym_count, 9);
        check_output("t4_overflow_cnt", overflow_cnt, 2);

        $display("[TB] phase selection and sync realignment");
        phase_sel = 4'd2;
        base = int'(m_sym);
        apply_stimulus(1, 1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 2'b01);
        for (int k = 0; k < 11; k++)
            apply_stimulus(1, 0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 2'b01);
        idle(3);
        check_output("t5_three_selected", sym_count, base + 3);
        for (int k = 0; k < 5; k++)
            apply_stimulus(1, 0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 2'b10);
        apply_stimulus(1, 1, 40, -40, 2'b10);
        for (int k = 0; k < 6; k++)
            apply_stimulus(1, 0, k * 3 - 8, 8 - k * 3, 2'b10);
        idle(3);
        check_output("t5_sync_realign", sym_count, base + 3 + 1 + 2);
        phase_sel = 4'd5;
        for (int k = 0; k < 8; k++)
            apply_stimulus(1, k == 0, k, -k, 2'b01);
        idle(3);
        check_output("t5_phase_out_of_range", sym_count, base + 6);

        $display("[TB] reset mid-operation");
        phase_sel = 4'd0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            apply_stimulus(1, 1, k + 1, -k - 1, 2'b01);
        idle(2);
        apply_stimulus(1, 1, 6, 6, 2'b10);
        reset_dut();
        out_ready = 1'b1;
        check_output("t6_og_valid", og_valid, 0);
        check_output("t6_sym_count", sym_count, 0);
        check_output("t6_overflow_cnt", overflow_cnt, 0);
        check_output("t6_counter_v", counter_v, 0);
        check_output("t6_i_dec", i_dec, 0);
        idle(6);
        check_output("t6_no_stale", sym_count, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/qam_rx_demap.md
Name: qam_rx_demap

Overview:
Parametrised successor to the fixed QAM16 receiver top. Accepts oversampled signed I/Q samples and picks one sample per symbol using a programmable phase. Slices the chosen sample to the nearest constellation point for QPSK, QAM16 or QAM64 (runtime mode), Gray-decodes it to bits and buffers the result in an output FIFO with a valid/ready handshake. Sits between the receive filter/upsampler and the bit sink.

Parameters:
IW, 8, signed input sample width (>=4)
OSR, 4, samples per symbol (2..2^CNT_W)
CNT_W, 4, phase counter width
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
DW, 6, output data width (bits per symbol of the largest mode)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  sample strobe
i_in  in  IW  signed I sample
q_in  in  IW  signed Q sample
sync  in  1  with in_valid: this sample is phase 0
phase_sel  in  CNT_W  sampling phase (0..OSR-1)
mode  in  2  00 QPSK, 01 QAM16, 10 QAM64, 11 treated as 01
counter_v  out  CNT_W  current sample phase counter
i_dec  out  4  signed sliced I level of last decoded symbol
q_dec  out  4  signed sliced Q level of last decoded symbol
og_data  out  DW  FIFO head, right-justified, upper bits 0
og_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head
sym_count  out  16  symbols written to FIFO, wraps
overflow_cnt  out  8  symbols dropped on full FIFO, saturates at 255

Behaviour:
- Reset (1 cycle is enough): counter_v=0, i_dec=q_dec=0, og_valid=0, og_data=0, sym_count=0, overflow_cnt=0, pipeline valids cleared, FIFO emptied. Reset mid-operation discards all in-flight and buffered symbols.
- Phase counter: advances only on in_valid. It wraps OSR-1 -> 0. in_valid&&sync forces the current sample's phase to 0, and the counter is 1 (mod OSR) afterwards. counter_v shows the phase the next valid sample will get.
- Selection: a sample is taken when in_valid and its phase == phase_sel. Changes to phase_sel apply from the next sample. phase_sel>=OSR never selects.
- Stage 1 (edge E0): register i_in, q_in, mode and a valid bit. Mode is carried with the sample, so in-flight symbols decode in their own mode.
- Stage 2 (E1): per axis, L = 2, 4 or 8 levels. Level = clamp(x|1, -(L-1), L-1). x|1 is two's-complement OR with 1, which equals 2*floor(x/2)+1, so even inputs round upward. Then n = (level+L-1)/2 and gray = n^(n>>1), giving b = 1, 2 or 3 bits per axis. Symbol = {I_gray, Q_gray}, 2b bits, right-justified in DW. i_dec/q_dec update here.
- Write (E2): the symbol is written to the FIFO and sym_count increments. og_valid rises after E2 if the FIFO was empty. Total latency is 3 edges from the accepting edge.
- Read: a head is popped on an edge with og_valid&&out_ready. og_data is 0 whenever og_valid=0.
- Full: if a write arrives while the FIFO is full and there is no simultaneous pop, the symbol is dropped, overflow_cnt increments (saturating) and sym_count does not change.
- Full with a simultaneous pop: both the write and the pop succeed.
- Empty: a write while empty presents that symbol at the head after the write edge. out_ready while empty has no effect.
- Throughput: one symbol per cycle is sustained. With OSR>=2, at most one selection occurs per OSR valid samples.

Test Plan:
QAM16, OSR=4, phase_sel=0, sync on first sample, out_ready=1, i_in=3, q_in=-1 at phase 0 -> i_dec=3, q_dec=-1, og_data=0x09, og_valid 3 edges after the accepting edge for exactly 1 cycle; sym_count=1.
QAM16 clamp/tie, IW=8: (i=100, q=-128) -> 0x08; (i=0, q=2) -> level (1,3) -> 0x0E.
QAM64: (i=5, q=-7) -> 0x28. QPSK: (i=-1, q=1) -> 0x01. Mode switched between back-to-back symbols -> each symbol decodes in its own mode.
Overflow: out_ready=0, 6 symbols -> og_valid=1, sym_count=4, overflow_cnt=2. Then out_ready=1 -> first 4 symbols drain in order and og_valid falls.
Phase/sync: phase_sel=2, continuous in_valid -> counter_v 0,1,2,3,0... and only every 4th sample is decoded. sync asserted mid-stream -> the selection point realigns to 2 samples after the sync sample.
Reset mid-operation: 3 symbols buffered plus 1 in flight, reset for 1 cycle -> og_valid=0, counters=0, and no stale symbol appears afterwards.
